noise_fill_scheduler: RTL and testbench

Sequences `noise_matrix_filler` across GAN layers and time-shares two ping-pong noise BRAM banks between the filler (writer) and the layer datapath (reader). A host queues fill jobs by size code; the scheduler starts the filler on the free bank and steers its write port to that bank. Filled banks are handed to the consumer in fill order, and the consumer returns each bank when it has finished reading.

---
 rtl/noise_sched_pkg.sv | 29 ++
 rtl/noise_bank_slot.sv | 55 +++++
 rtl/noise_fill_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_noise_fill_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noise_sched_pkg.sv
// Shared types for the noise bank scheduler: bank and controller state
// encodings, the largest legal size code and the size-to-dimension helper.
package noise_sched_pkg;

   typedef enum logic [1:0] {
      BANK_EMPTY   = 2'd0,
      BANK_FILLING = 2'd1,
      BANK_READY   = 2'd2,
      BANK_IN_USE  = 2'd3
   } bank_state_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_FILL  = 2'd2
   } fsm_state_t;

   localparam logic [2:0] SIZE_MAX = 3'd5;

   // Matrix edge length for a size code; only meaningful for codes 0..SIZE_MAX.
   function automatic logic [7:0] size_to_dim(input logic [2:0] size);
      return 8'(32'd4 << size);
   endfunction

   function automatic logic size_legal(input logic [2:0] size);
      return size <= SIZE_MAX;
   endfunction

endpackage

// File: rtl/noise_bank_slot.sv
// One noise bank's bookkeeping: lifecycle state plus the size code it was filled with.
module noise_bank_slot
   import noise_sched_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_alloc,
   input  logic [2:0] i_size,
   input  logic       i_done,
   input  logic       i_take,
   input  logic       i_release,
   input  logic       i_abort,
   output logic [1:0] o_state,
   output logic [2:0] o_size
);

   bank_state_t r_state;
   logic [2:0]  r_size;

   // Each strobe only acts in the one state it belongs to; stray strobes are ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= BANK_EMPTY;
         r_size  <= '0;
      end else begin
         case (r_state)
            BANK_EMPTY: begin
               if (i_alloc) begin
                  r_state <= BANK_FILLING;
                  r_size  <= i_size;
               end
            end
            BANK_FILLING: begin
               if (i_abort)
                  r_state <= BANK_EMPTY;
               else if (i_done)
                  r_state <= BANK_READY;
            end
            BANK_READY: begin
               if (i_take)
                  r_state <= BANK_IN_USE;
            end
            BANK_IN_USE: begin
               if (i_release)
                  r_state <= BANK_EMPTY;
            end
            default: r_state <= BANK_EMPTY;
         endcase
      end
   end

   assign o_state = r_state;
   assign o_size  = r_size;

endmodule

// File: rtl/noise_fill_scheduler.sv
// Ping-pong noise bank scheduler: runs the matrix filler on the free bank and hands
// filled banks to the consumer in fill order. Fill watchdog: NOISE_SCHED_WATCHDOG_EN.
//
// state    | meaning
// ST_IDLE  | waiting for a host fill request on the bank at wr_ptr
// ST_START | one-cycle fill_start pulse to the filler
// ST_FILL  | filler owns the write port of bank wr_ptr until fill_done
module noise_fill_scheduler
   import noise_sched_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 14
`ifdef NOISE_SCHED_WATCHDOG_EN
   ,
   parameter int TIMEOUT_CYCLES = 20000
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [2:0]            cfg_size,
   output logic                  cfg_err,
   output logic                  fill_start,
   output logic [2:0]            fill_size,
   input  logic                  fill_done,
   input  logic [ADDR_WIDTH-1:0] fill_addr,
   input  logic [DATA_WIDTH-1:0] fill_wdata,
   input  logic                  fill_we,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic [DATA_WIDTH-1:0] bram_wdata,
   output logic [1:0]            bram_we,
   output logic                  cons_valid,
   output logic                  cons_bank,
   output logic [2:0]            cons_size,
   input  logic                  cons_take,
   input  logic                  cons_release,
   input  logic                  cons_release_bank,
   output logic                  busy
`ifdef NOISE_SCHED_WATCHDOG_EN
   ,
   output logic                  timeout_err
`endif
);

   fsm_state_t r_state;
   logic       r_wr_ptr;
   logic       r_rd_ptr;
   logic       r_fill_start;
   logic [2:0] r_fill_size;
   logic       r_busy;
   logic       r_cfg_err;

   logic [1:0] w_bank_st   [2];
   logic [2:0] w_bank_size [2];
   logic [1:0] w_alloc;
   logic [1:0] w_done;
   logic [1:0] w_take;
   logic [1:0] w_release;
   logic [1:0] w_abort;
   logic       w_cfg_hs;
   logic       w_size_ok;
   logic       w_fill_done;
   logic       w_cons_take;
   logic       w_timeout;

   // Readiness comes only from registered bank state, so a same-cycle release
   // cannot open the request port until the following cycle.
   assign cfg_ready   = (r_state == ST_IDLE) && (w_bank_st[r_wr_ptr] == BANK_EMPTY);
   assign w_cfg_hs    = cfg_valid && cfg_ready;
   assign w_size_ok   = size_legal(cfg_size);
   assign w_fill_done = (r_state == ST_FILL) && fill_done;
   assign cons_valid  = (w_bank_st[r_rd_ptr] == BANK_READY);
   assign w_cons_take = cons_valid && cons_take;

   always_comb begin
      w_alloc   = '0;
      w_done    = '0;
      w_take    = '0;
      w_release = '0;
      w_abort   = '0;
      w_alloc[r_wr_ptr]           = w_cfg_hs && w_size_ok;
      w_done[r_wr_ptr]            = w_fill_done;
      w_take[r_rd_ptr]            = w_cons_take;
      w_release[cons_release_bank] = cons_release;
      w_abort[r_wr_ptr]           = w_timeout;
   end

   for (genvar g = 0; g < 2; g++) begin : g_bank
      noise_bank_slot u_slot (
         .clk       (clk),
         .rst       (rst),
         .i_alloc   (w_alloc[g]),
         .i_size    (cfg_size),
         .i_done    (w_done[g]),
         .i_take    (w_take[g]),
         .i_release (w_release[g]),
         .i_abort   (w_abort[g]),
         .o_state   (w_bank_st[g]),
         .o_size    (w_bank_size[g])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_wr_ptr     <= 1'b0;
         r_rd_ptr     <= 1'b0;
         r_fill_start <= 1'b0;
         r_fill_size  <= '0;
         r_busy       <= 1'b0;
         r_cfg_err    <= 1'b0;
      end else begin
         r_fill_start <= 1'b0;
         if (w_cons_take)
            r_rd_ptr <= ~r_rd_ptr;
         case (r_state)
            ST_IDLE: begin
               if (w_cfg_hs) begin
                  if (w_size_ok) begin
                     r_fill_size  <= cfg_size;
                     r_fill_start <= 1'b1;
                     r_busy       <= 1'b1;
                     r_state      <= ST_START;
                  end else begin
                     r_cfg_err <= 1'b1;
                  end
               end
            end
            ST_START: r_state <= ST_FILL;
            ST_FILL: begin
               if (w_fill_done) begin
                  r_wr_ptr <= ~r_wr_ptr;
                  r_busy   <= 1'b0;
                  r_state  <= ST_IDLE;
               end else if (w_timeout) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // The filler's write port is steered to the bank being filled; dropped otherwise.
   always_comb begin
      bram_we = 2'b00;
      if (r_state == ST_FILL)
         bram_we[r_wr_ptr] = fill_we;
   end

   assign bram_addr  = fill_addr;
   assign bram_wdata = fill_wdata;
   assign fill_start = r_fill_start;
   assign fill_size  = r_fill_size;
   assign busy       = r_busy;
   assign cfg_err    = r_cfg_err;
   assign cons_bank  = r_rd_ptr;
   assign cons_size  = w_bank_size[r_rd_ptr];

`ifdef NOISE_SCHED_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] r_wd_cnt;
   logic            r_timeout_err;

   // Down-counter loaded while START so it reaches zero on the last allowed FILL cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wd_cnt      <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         if (r_state == ST_START)
            r_wd_cnt <= WD_W'(TIMEOUT_CYCLES - 1);
         else if ((r_state == ST_FILL) && (r_wd_cnt != '0))
            r_wd_cnt <= r_wd_cnt - 1'b1;
         if (w_timeout)
            r_timeout_err <= 1'b1;
      end
   end

   assign w_timeout   = (r_state == ST_FILL) && !fill_done && (r_wd_cnt == '0);
   assign timeout_err = r_timeout_err;
`else
   assign w_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_noise_fill_scheduler.sv
// Scoreboard bench for noise_fill_scheduler: a bank-lifecycle model predicts fill_start
// sizes and consumer hand-outs; monitors pop and compare when the DUT presents them.
module tb_noise_fill_scheduler;

   localparam int E = 0, F = 1, R = 2, U = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [2:0]  cfg_size = '0;
   logic        cfg_err;
   logic        fill_start;
   logic [2:0]  fill_size;
   logic        fill_done = 1'b0;
   logic [13:0] fill_addr = '0;
   logic [15:0] fill_wdata = '0;
   logic        fill_we = 1'b0;
   logic [13:0] bram_addr;
   logic [15:0] bram_wdata;
   logic [1:0]  bram_we;
   logic        cons_valid;
   logic        cons_bank;
   logic [2:0]  cons_size;
   logic        cons_take = 1'b0;
   logic        cons_release = 1'b0;
   logic        cons_release_bank = 1'b0;
   logic        busy;
`ifdef NOISE_SCHED_WATCHDOG_EN
   logic        timeout_err;
`endif

   noise_fill_scheduler #(
      .DATA_WIDTH (16),
      .ADDR_WIDTH (14)
`ifdef NOISE_SCHED_WATCHDOG_EN
      ,
      .TIMEOUT_CYCLES (50)
`endif
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .cfg_valid         (cfg_valid),
      .cfg_ready         (cfg_ready),
      .cfg_size          (cfg_size),
      .cfg_err           (cfg_err),
      .fill_start        (fill_start),
      .fill_size         (fill_size),
      .fill_done         (fill_done),
      .fill_addr         (fill_addr),
      .fill_wdata        (fill_wdata),
      .fill_we           (fill_we),
      .bram_addr         (bram_addr),
      .bram_wdata        (bram_wdata),
      .bram_we           (bram_we),
      .cons_valid        (cons_valid),
      .cons_bank         (cons_bank),
      .cons_size         (cons_size),
      .cons_take         (cons_take),
      .cons_release      (cons_release),
      .cons_release_bank (cons_release_bank),
      .busy              (busy)
`ifdef NOISE_SCHED_WATCHDOG_EN
      ,
      .timeout_err       (timeout_err)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: per-bank lifecycle, recorded size, and the two pointers.
   int         m_st [2];
   logic [2:0] m_sz [2];
   int         m_wr, m_rd;
   bit         m_err, m_to;

   logic [2:0] q_start [$];
   logic [3:0] q_cons  [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_st[i] = E;
         m_sz[i] = '0;
      end
      m_wr  = 0;
      m_rd  = 0;
      m_err = 0;
      m_to  = 0;
      q_cons.delete();
   endfunction

   task automatic check_state(input bit busy_exp);
      check("cfg_ready", cfg_ready, !busy_exp && (m_st[m_wr] == E));
      check("cons_valid", cons_valid, m_st[m_rd] == R);
      if (m_st[m_rd] == R) begin
         check("cons_bank", cons_bank, m_rd);
         check("cons_size", cons_size, m_sz[m_rd]);
      end
      check("cfg_err", cfg_err, m_err);
      check("busy", busy, busy_exp);
`ifdef NOISE_SCHED_WATCHDOG_EN
      check("timeout_err", timeout_err, m_to);
`endif
   endtask

   // Monitors: consume expectations whenever the DUT starts a fill or hands out a bank.
   always @(negedge clk) begin
      if (!rst && fill_start) begin
         if (q_start.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL fill_start_unexpected: got pulse, expected none at %0t", $time);
         end else begin
            check("fill_size_at_start", fill_size, q_start.pop_front());
         end
      end
      if (!rst && cons_valid && cons_take) begin
         if (q_cons.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL take_unexpected: got bank %0d, expected no ready bank at %0t", cons_bank, $time);
         end else begin
            logic [3:0] e;
            e = q_cons.pop_front();
            check("take_bank", cons_bank, e[3]);
            check("take_size", cons_size, e[2:0]);
         end
      end
   end

   task automatic apply_reset();
      rst = 1'b1;
      cfg_valid = 0; fill_done = 0; fill_we = 0; cons_take = 0; cons_release = 0;
      tick();
      tick();
      rst = 1'b0;
      model_reset();
      check_state(0);
      check("fill_start_rst", fill_start, 0);
      check("bram_we_rst", bram_we, 0);
   endtask

   // One idle-side cycle: optional take/release, plus noise that must be ignored
   // (filler writes, stray fill_done, requests while the write bank is not free).
   task automatic cons_cycle(input bit take, input bit rel, input bit rb);
      bit tk_ok, rl_ok;
      cons_take = take;
      cons_release = rel;
      cons_release_bank = rb;
      fill_done = 1'($urandom_range(0, 1));
      fill_we = 1'b1;
      fill_addr = 14'($urandom);
      cfg_size = 3'($urandom_range(0, 5));
      cfg_valid = (m_st[m_wr] != E) ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      check("bram_we_idle", bram_we, 0);
      tk_ok = take && (m_st[m_rd] == R);
      rl_ok = rel && (m_st[rb] == U);
      tick();
      cons_take = 0; cons_release = 0; fill_done = 0; fill_we = 0; cfg_valid = 0;
      if (rl_ok) m_st[rb] = E;
      if (tk_ok) begin
         m_st[m_rd] = U;
         m_rd ^= 1;
      end
      check_state(0);
   endtask

   task automatic do_fill(input logic [2:0] sz, input int nwr, input bit side_rel, input bit rb);
      bit         rl_ok;
      logic [1:0] we_exp;
      check("cfg_ready_pre", cfg_ready, m_st[m_wr] == E);
      cfg_valid = 1'b1;
      cfg_size = sz;
      cons_release = side_rel;
      cons_release_bank = rb;
      rl_ok = side_rel && (m_st[rb] == U);
      if (sz <= 5) q_start.push_back(sz);
      tick();
      cfg_valid = 0;
      cons_release = 0;
      if (rl_ok) m_st[rb] = E;
      if (sz > 5) begin
         m_err = 1;
         check_state(0);
         return;
      end
      m_st[m_wr] = F;
      m_sz[m_wr] = sz;
      fill_we = 1'b1;
      #1;
      check("bram_we_start", bram_we, 0);
      check_state(1);
      tick();
      for (int k = 0; k < nwr; k++) begin
         fill_we = 1'($urandom_range(0, 1));
         fill_addr = 14'($urandom);
         fill_wdata = 16'($urandom);
         #1;
         we_exp = fill_we ? (2'b01 << m_wr) : 2'b00;
         check("bram_we_fill", bram_we, we_exp);
         check("bram_addr", bram_addr, fill_addr);
         check("bram_wdata", bram_wdata, fill_wdata);
         check("fill_size_hold", fill_size, sz);
         tick();
      end
      fill_we = 0;
      fill_done = 1'b1;
      tick();
      fill_done = 0;
      m_st[m_wr] = R;
      q_cons.push_back({m_wr[0], sz});
      m_wr ^= 1;
      check_state(0);
   endtask

   task automatic reset_mid_fill();
      check("cfg_ready_pre_rst", cfg_ready, m_st[m_wr] == E);
      cfg_valid = 1'b1;
      cfg_size = 3'd3;
      q_start.push_back(3'd3);
      tick();
      cfg_valid = 0;
      m_st[m_wr] = F;
      tick();
      fill_we = 1'b1;
      #1;
      check("bram_we_before_rst", bram_we, 2'b01 << m_wr);
      rst = 1'b1;
      #1;
      check("bram_we_in_rst", bram_we, 0);
      check("busy_in_rst", busy, 0);
      fill_we = 0;
      tick();
      rst = 1'b0;
      model_reset();
      check_state(0);
      fill_done = 1'b1;
      tick();
      fill_done = 0;
      tick();
      check_state(0);
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: got no finish, expected finish before 1ms");
      $fatal(1, "bench time limit");
   end

   initial begin
      model_reset();
      apply_reset();

      do_fill(3'd0, 3, 0, 0);
      cons_cycle(1, 0, 0);
      cons_cycle(0, 1, 0);
      do_fill(3'd1, 2, 0, 0);
      do_fill(3'd2, 2, 0, 0);
      cons_cycle(0, 0, 0);
      cons_cycle(1, 0, 0);
      cons_cycle(1, 0, 0);
      cons_cycle(1, 1, 1);
      cons_cycle(0, 1, 1);
      cons_cycle(0, 1, 0);
      do_fill(3'd6, 0, 0, 0);
      do_fill(3'd7, 0, 0, 0);

      reset_mid_fill();

      for (int it = 0; it < 200; it++) begin
         int act;
         act = $urandom_range(0, 3);
         if (act == 0 && m_st[m_wr] == E)
            do_fill(3'($urandom_range(0, 7)), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         else
            cons_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
      end

`ifdef NOISE_SCHED_WATCHDOG_EN
      apply_reset();
      cfg_valid = 1'b1;
      cfg_size = 3'd2;
      q_start.push_back(3'd2);
      tick();
      cfg_valid = 0;
      m_st[0] = F;
      tick();
      repeat (49) tick();
      check("timeout_err_before", timeout_err, 0);
      check("busy_before_timeout", busy, 1);
      tick();
      m_st[0] = E;
      m_to = 1;
      check_state(0);
      do_fill(3'd1, 1, 0, 0);
`endif

      check("start_queue_drained", q_start.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
